// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared widths and saturation limits for the MAC datapath
package mac_pkg;

  localparam int PROD_W        = 16;
  localparam int ACC_W_DEFAULT = 24;

  // Limits are returned as w-bit patterns in the low bits of a 32-bit word.
  function automatic logic [31:0] umax_limit(input int w);
    logic [32:0] t;
    t = (33'd1 << w) - 33'd1;
    return t[31:0];
  endfunction

  function automatic logic [31:0] smax_limit(input int w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  function automatic logic [31:0] smin_limit(input int w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/mac_multiplier.sv
// rtl/mac_multiplier.sv - registered 8x8 multiply stage with valid/clear pass-through
module mac_multiplier
  import mac_pkg::*;
#(
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        a,
  input  logic [7:0]        b,
  input  logic              valid,
  input  logic              clear,
  output logic [PROD_W-1:0] product,
  output logic              prod_valid,
  output logic              prod_clear
);

  logic [PROD_W-1:0] a_x;
  logic [PROD_W-1:0] b_x;
  logic [PROD_W-1:0] mult;

  // Extending to the product width first makes the low 16 bits correct for both signednesses.
  always_comb begin
    a_x = {8'd0, a};
    b_x = {8'd0, b};
    if (SIGNED != 0) begin
      a_x = {{8{a[7]}}, a};
      b_x = {{8{b[7]}}, b};
    end
    mult = a_x * b_x;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      product    <= '0;
      prod_valid <= 1'b0;
      prod_clear <= 1'b0;
    end else begin
      prod_valid <= valid;
      prod_clear <= clear;
      if (valid) product <= mult;
    end
  end

endmodule

// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - two-stage saturating multiply-accumulate with byte readout
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEFAULT,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data_a_in,
  input  logic [7:0]       data_b_in,
  input  logic             clear_mult_in,
  input  logic             valid_in,
  input  logic [1:0]       byte_sel,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  output logic             overflow,
  output logic [7:0]       term_count,
  output logic [7:0]       result_byte
);

  localparam logic [ACC_W-1:0] UMAX = ACC_W'(umax_limit(ACC_W));
  localparam logic [ACC_W-1:0] SMAX = ACC_W'(smax_limit(ACC_W));
  localparam logic [ACC_W-1:0] SMIN = ACC_W'(smin_limit(ACC_W));

  logic [PROD_W-1:0] product;
  logic              v1;
  logic              clr1;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W:0]    acc_x;
  logic [ACC_W:0]    prod_x;
  logic [ACC_W:0]    sum;
  logic              clamp;
  logic [ACC_W-1:0]  acc_next;
  logic [31:0]       acc_wide;
  logic [7:0]        byte_next;

  mac_multiplier #(
    .SIGNED(SIGNED)
  ) u_mult (
    .clk       (clk),
    .rst       (rst),
    .a         (data_a_in),
    .b         (data_b_in),
    .valid     (valid_in),
    .clear     (clear_mult_in),
    .product   (product),
    .prod_valid(v1),
    .prod_clear(clr1)
  );

  // One guard bit above the accumulator exposes carry-out / signed overflow.
  always_comb begin
    if (SIGNED != 0) begin
      acc_x  = {acc[ACC_W-1], acc};
      prod_x = {{(ACC_W + 1 - PROD_W){product[PROD_W-1]}}, product};
    end else begin
      acc_x  = {1'b0, acc};
      prod_x = {{(ACC_W + 1 - PROD_W){1'b0}}, product};
    end
    sum = acc_x + prod_x;
    if (SIGNED != 0) begin
      clamp    = sum[ACC_W] ^ sum[ACC_W-1];
      acc_next = sum[ACC_W] ? SMIN : SMAX;
    end else begin
      clamp    = sum[ACC_W];
      acc_next = UMAX;
    end
    if (!clamp) acc_next = sum[ACC_W-1:0];
  end

  always_comb begin
    acc_wide             = '0;
    acc_wide[ACC_W-1:0]  = acc;
    case (byte_sel)
      2'd0:    byte_next = acc_wide[7:0];
      2'd1:    byte_next = acc_wide[15:8];
      2'd2:    byte_next = acc_wide[23:16];
      default: byte_next = acc_wide[31:24];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc         <= '0;
      acc_valid   <= 1'b0;
      overflow    <= 1'b0;
      term_count  <= '0;
      result_byte <= '0;
    end else begin
      acc_valid   <= v1;
      result_byte <= byte_next;
      if (v1 && clr1) begin
        acc        <= prod_x[ACC_W-1:0];
        overflow   <= 1'b0;
        term_count <= 8'd1;
      end else if (clr1) begin
        acc        <= '0;
        overflow   <= 1'b0;
        term_count <= 8'd0;
      end else if (v1) begin
        acc <= acc_next;
        if (clamp) overflow <= 1'b1;
        if (term_count != 8'hFF) term_count <= term_count + 8'd1;
      end
    end
  end

  assign acc_out = acc;

endmodule

// File: doc/mac_accumulator.md
MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 SHALL have parameter ACC_W, default 24: accumulator width, legal 17..32.
REQ-002 SHALL have parameter SIGNED, default 0: 0 = unsigned operands, 1 = two's-complement operands.
REQ-003 SHALL have port clk, input, 1: clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port data_a_in, input, 8: operand A from registered input stage.
REQ-006 SHALL have port data_b_in, input, 8: operand B from registered input stage.
REQ-007 SHALL have port clear_mult_in, input, 1: clear accumulator.
REQ-008 SHALL have port valid_in, input, 1: operands valid this cycle.
REQ-009 SHALL have port byte_sel, input, 2: selects accumulator byte for result_byte.
REQ-010 SHALL have port acc_out, output, ACC_W: current accumulator value.
REQ-011 SHALL have port acc_valid, output, 1: one-cycle pulse on each accumulate update.
REQ-012 SHALL have port overflow, output, 1: sticky saturation flag.
REQ-013 SHALL have port term_count, output, 8: products accumulated since last clear.
REQ-014 SHALL have port result_byte, output, 8: registered byte of acc_out chosen by byte_sel.

Function
REQ-015 Stage 1 SHALL, when valid_in=1, register product = A*B (16 bits, signed or unsigned per SIGNED) with a copy of clear_mult_in and a stage valid bit v1.
REQ-016 When valid_in=0, stage 1 SHALL set v1=0; the product register holds its value.
REQ-017 Stage 2 SHALL, when v1=1 and the clear copy=0, set acc <= sat(acc + ext(product)), where ext is zero- or sign-extension to ACC_W+1 bits.
REQ-018 Stage 2 SHALL, when v1=1 and the clear copy=1, set acc <= ext(product), clear overflow, and set term_count=1 (clear-and-load).
REQ-019 clear_mult_in=1 with valid_in=0 SHALL, one cycle later, set acc=0, overflow=0, and term_count=0, with no acc_valid pulse.
REQ-020 Saturation when unsigned SHALL clamp to 2^ACC_W-1.
REQ-021 Saturation when signed SHALL clamp to +2^(ACC_W-1)-1 or -2^(ACC_W-1).
REQ-022 Any clamp SHALL set overflow=1; overflow stays set until a clear or reset.
REQ-023 term_count SHALL increment on each non-clear stage-2 update and saturate at 255.
REQ-024 Latency: valid_in at edge N SHALL give updated acc_out and an acc_valid pulse after edge N+2.
REQ-025 Back-to-back valid_in SHALL be accepted every cycle at full throughput with no stall.
REQ-026 result_byte SHALL be registered: byte_sel 0..3 selects acc bits [8k+7:8k], sampling the acc value present at that edge; bits beyond ACC_W read 0.
REQ-027 A clear in stage 2 coinciding with a new stage-1 capture SHALL NOT affect that new product, which accumulates onto the cleared or loaded value next cycle.

Reset
REQ-028 rst=1 SHALL immediately zero the product register, v1, clear copy, acc, acc_out, acc_valid, overflow, term_count, and result_byte.
REQ-029 Reset mid-operation SHALL discard in-flight products; no acc_valid pulse SHALL occur for them after release.
REQ-030 The first valid_in SHALL be accepted on the first rising edge with rst=0.

Structure
REQ-031 Package mac_pkg SHALL hold PROD_W=16, the default ACC_W, and functions for unsigned and signed saturation limits.
REQ-032 Stage 1 SHALL be sub-module mac_multiplier (registered 8x8 multiply with valid/clear pass-through); stage 2, flags, and readout SHALL stay in mac_accumulator.

Verification
REQ-033 Unsigned, clear-load 3*4, then 5*6 and 7*8 -> acc 12, 42, 98 on successive acc_valid pulses; term_count 1,2,3.
REQ-034 Unsigned, ACC_W=17, repeated 255*255 -> third update clamps to 0x1FFFF, overflow=1; next clear-load 1*1 -> acc=1, overflow=0.
REQ-035 Signed, clear-load (-128)*127 then (-1)*(-1) -> acc -16256 then -16255; acc_out sign-correct at ACC_W=24.
REQ-036 Standalone clear (valid_in=0) after acc=0x123456 -> acc=0 and term_count=0 one cycle later with no acc_valid; then byte_sel=2 -> result_byte=0x00, versus 0x12 before the clear.
REQ-037 rst asserted one cycle after valid_in with 10*10 -> outputs zero immediately, no acc_valid after release; 300 back-to-back 1*1 after release -> term_count stops at 255, acc=300.
